pu_result_collector: RTL and testbench
======================================

// Module: pu_result_collector
// PURPOSE
//  Downstream stage of the 4-input processing unit (multiply, register, adder tree, activation).
//  Captures one PU activation per accepted beat into an N_OUT-entry result buffer.
//  Tracks the running maximum and its index (argmax) across one frame of N_OUT neuron outputs.
//  Signals frame completion to the layer controller; exposes the buffer through a read port for the next layer.
// PARAMETERS
//  DW     32  data width; matches PU output width; values are signed two's complement
//  N_OUT  10  results per frame (neurons per layer); must be >= 2
//  IW     $clog2(N_OUT)  index/address width (derived, not overridden)
// PORTS
//  clk       in   1      single clock, all state on rising edge
//  rst       in   1      asynchronous, active-low reset (rst=0 resets immediately)
//  start     in   1      begin (or restart) a frame
//  in_valid  in   1      in_data carries a PU activation this cycle
//  in_data   in   DW     PU activation output
//  in_ready  out  1      collector accepts a beat this cycle
//  rd_addr   in   IW     buffer read address
//  rd_data   out  DW     buffer[rd_addr], combinational; 0 if rd_addr >= N_OUT
//  max_val   out  DW     largest value of the last/current frame
//  max_idx   out  IW     index of max_val within the frame
//  busy      out  1      high while in COLLECT
//  done      out  1      one-cycle pulse when the last beat of a frame is accepted
//  drop_err  out  1      sticky: a beat arrived while in_ready=0
// BEHAVIOUR
//  - Reset values: state IDLE, cnt=0, buffer all 0, max_val=0, max_idx=0, busy=0, done=0, drop_err=0.
//    Reset asserted mid-frame aborts the frame at once; no partial done.
//  - FSM IDLE -> COLLECT -> DONE -> IDLE.
//    IDLE: in_ready=0. start=1 -> COLLECT; cnt=0, drop_err=0, first-beat flag set.
//    COLLECT: in_ready=1, busy=1. Accept = in_valid & in_ready.
//      On accept: buf[cnt]<=in_data, cnt<=cnt+1.
//      First beat loads max_val/max_idx unconditionally; later beats replace them only if
//      $signed(in_data) > $signed(max_val). Strict compare, so ties keep the lowest index.
//      Accept with cnt==N_OUT-1 -> DONE.
//      in_valid=0 cycles (gaps) hold all state.
//      start=1 in COLLECT restarts the frame: cnt=0, max re-armed, buffer not cleared.
//      start wins over a simultaneous accept; that beat is discarded and not flagged.
//    DONE: one cycle, done=1, in_ready=0, busy=0; start ignored; -> IDLE.
//  - Result retention: max_val/max_idx/buffer hold after DONE until the next accepted beat of a new frame.
//  - Latency: buffer and max are updated and visible on outputs the cycle after accept.
//    done rises the cycle after the final accept.
//  - drop_err: set on in_valid=1 while in_ready=0 (IDLE or DONE); cleared only by start or reset.
//  - cnt never wraps: it saturates at frame end via DONE and never exceeds N_OUT-1.
// STRUCTURE
//  - Shared package: DW default, state encoding (IDLE=2'd0, COLLECT=2'd1, DONE=2'd2).
//  - Sub-module max_tracker: registered signed max/argmax with load-first and strict-greater
//    update (clk, rst, clr, en, idx, val -> max_val, max_idx).
//  - Top holds the FSM, counter, buffer and read mux.
// TESTING
//  1 Reset: rst=0 mid-COLLECT after 4 beats -> all outputs at reset values at once; rd_data=0 for addr 0..3.
//  2 Full frame, N_OUT=10: data 3,7,-2,7,0,1,5,6,-9,2, back-to-back ->
//    done pulse 1 cycle after 10th beat; max_val=7, max_idx=1; rd_addr=8 -> -9.
//  3 Same frame with random in_valid gaps -> identical results; busy high throughout, in_ready low after DONE.
//  4 start asserted after 5 beats, then 10 beats of 100..109 ->
//    max_val=109, max_idx=9; beat coincident with start is not stored.
//  5 in_valid=1 in IDLE with data 55 -> drop_err=1, buffer and max unchanged; next start clears drop_err.
//  6 All-negative frame -8,-3,-3,-20,... (others < -3) -> max_val=-3, max_idx=1 (tie keeps first).

Source files
------------

// File: rtl/pu_result_collector_pkg.sv
// rtl/pu_result_collector_pkg.sv - shared types and defaults for the PU result collector
package pu_result_collector_pkg;

    localparam int DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/pu_result_collector_max_tracker.sv
// rtl/pu_result_collector_max_tracker.sv - registered signed running max / argmax
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   clr              re-arm: the next enabled value loads unconditionally
//   en               a value is presented this cycle
//   idx, val         index and signed value of the presented sample
//   max_val, max_idx registered maximum and its index
module pu_result_collector_max_tracker #(
    parameter int DW = 32,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [IW-1:0] idx,
    input  logic [DW-1:0] val,
    output logic [DW-1:0] max_val,
    output logic [IW-1:0] max_idx
);

    logic          first_q, first_d;
    logic [DW-1:0] max_val_q, max_val_d;
    logic [IW-1:0] max_idx_q, max_idx_d;

    // clr has priority over en so a restart discards the coincident sample.
    // Clearing only re-arms; the old result stays visible until a new load.
    always_comb begin
        first_d   = first_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        if (clr) begin
            first_d = 1'b1;
        end else if (en) begin
            first_d = 1'b0;
            // Strict compare: ties keep the earlier (lower) index.
            if (first_q || ($signed(val) > $signed(max_val_q))) begin
                max_val_d = val;
                max_idx_d = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_q   <= 1'b1;
            max_val_q <= '0;
            max_idx_q <= '0;
        end else begin
            first_q   <= first_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign max_val = max_val_q;
    assign max_idx = max_idx_q;

endmodule

// File: rtl/pu_result_collector.sv
// rtl/pu_result_collector.sv - collects one frame of PU activations with running argmax
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   start              begin or restart a frame
//   in_valid, in_data  PU activation beat; in_ready high only while collecting
//   rd_addr, rd_data   combinational buffer read, 0 beyond N_OUT-1
//   max_val, max_idx   running maximum of the current/last frame and its index
//   busy               collecting a frame
//   done               one-cycle pulse after the last beat of a frame
//   drop_err           sticky: a beat was offered while in_ready was low
module pu_result_collector
    import pu_result_collector_pkg::*;
#(
    parameter  int DW    = DW_DEFAULT,
    parameter  int N_OUT = 10,
    localparam int IW    = $clog2(N_OUT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic [IW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] max_val,
    output logic [IW-1:0] max_idx,
    output logic          busy,
    output logic          done,
    output logic          drop_err
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N_OUT - 1);
    localparam logic [IW:0]   N_OUT_W  = (IW + 1)'(N_OUT);

    state_e        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          drop_err_q, drop_err_d;
    logic [DW-1:0] buf_q [N_OUT];
    logic [DW-1:0] buf_d [N_OUT];
    logic          restart;
    logic          beat_wr;

    assign in_ready = (state_q == ST_COLLECT);
    assign busy     = (state_q == ST_COLLECT);
    assign done     = (state_q == ST_DONE);
    assign drop_err = drop_err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drop_err_d = drop_err_q;
        restart    = 1'b0;
        beat_wr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COLLECT;
                    cnt_d   = '0;
                    restart = 1'b1;
                end
            end
            ST_COLLECT: begin
                // start wins over a coincident beat, which is silently discarded
                if (start) begin
                    cnt_d   = '0;
                    restart = 1'b1;
                end else if (in_valid) begin
                    beat_wr = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        // counter parks on the last index instead of wrapping
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (restart) begin
            drop_err_d = 1'b0;
        end
        // A beat dropped in the same cycle as start still counts as dropped.
        if (in_valid && !in_ready) begin
            drop_err_d = 1'b1;
        end
    end

    always_comb begin
        buf_d = buf_q;
        if (beat_wr) begin
            buf_d[cnt_q] = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            drop_err_q <= 1'b0;
            for (int i = 0; i < N_OUT; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drop_err_q <= drop_err_d;
            buf_q      <= buf_d;
        end
    end

    assign rd_data = ({1'b0, rd_addr} < N_OUT_W) ? buf_q[rd_addr] : '0;

    pu_result_collector_max_tracker #(
        .DW (DW),
        .IW (IW)
    ) u_max_tracker (
        .clk     (clk),
        .rst     (rst),
        .clr     (restart),
        .en      (beat_wr),
        .idx     (cnt_q),
        .val     (in_data),
        .max_val (max_val),
        .max_idx (max_idx)
    );

endmodule

// File: tb/tb_pu_result_collector.sv
// tb/tb_pu_result_collector.sv - self-checking bench for pu_result_collector
module tb_pu_result_collector;

    localparam int DW    = 32;
    localparam int N_OUT = 10;
    localparam int IW    = 4;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic [IW-1:0] rd_addr  = '0;
    logic          in_ready;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] max_val;
    logic [IW-1:0] max_idx;
    logic          busy;
    logic          done;
    logic          drop_err;

    pu_result_collector #(
        .DW    (DW),
        .N_OUT (N_OUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .max_val  (max_val),
        .max_idx  (max_idx),
        .busy     (busy),
        .done     (done),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int val;
    } sb_t;

    typedef struct {
        int d[10];
        bit gaps;
        int exp_max;
        int exp_idx;
        int probe_addr;
        int probe_val;
    } frame_t;

    sb_t    sb_q[$];
    frame_t tbl[3];
    int     beats[10];
    int     total = 0;
    int     bad   = 0;
    bit     m_first;
    int     m_max;
    int     m_idx;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        sb_q.delete();
        m_first = 1'b1;
    endtask

    task automatic feed_beats(input int n, input bit gaps);
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 400) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? beats[k] : $urandom;
            @(negedge clk);
            chk("busy_collect", busy, 1);
            chk("ready_collect", in_ready, 1);
            if (in_valid) begin
                sb_q.push_back('{idx: k, val: beats[k]});
                if (m_first || beats[k] > m_max) begin
                    m_max = beats[k];
                    m_idx = k;
                end
                m_first = 1'b0;
                k++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        if (k < n) begin
            total++;
            bad++;
            $display("FAIL feed_timeout: accepted %0d of %0d beats", k, n);
        end
    endtask

    task automatic finish_frame(input int emax, input int eidx, input int paddr, input int pval);
        sb_t e;
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("ready_in_done", in_ready, 0);
        chk("busy_in_done", busy, 0);
        chk("max_val_tbl", max_val, emax);
        chk("max_val_model", max_val, m_max);
        chk("max_idx_tbl", max_idx, eidx);
        chk("max_idx_model", max_idx, m_idx);
        chk("drop_err_clear", drop_err, 0);
        step();
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("ready_idle", in_ready, 0);
        while (sb_q.size() > 0) begin
            e       = sb_q.pop_front();
            rd_addr = IW'(e.idx);
            #1;
            chk("rd_scoreboard", rd_data, e.val);
        end
        rd_addr = IW'(paddr);
        #1;
        chk("rd_probe", rd_data, pval);
        rd_addr = 4'd13;
        #1;
        chk("rd_out_of_range", rd_data, 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0].d = '{3, 7, -2, 7, 0, 1, 5, 6, -9, 2};
        tbl[0].gaps = 1'b0; tbl[0].exp_max = 7;  tbl[0].exp_idx = 1;
        tbl[0].probe_addr = 8; tbl[0].probe_val = -9;
        tbl[1].d = '{3, 7, -2, 7, 0, 1, 5, 6, -9, 2};
        tbl[1].gaps = 1'b1; tbl[1].exp_max = 7;  tbl[1].exp_idx = 1;
        tbl[1].probe_addr = 8; tbl[1].probe_val = -9;
        tbl[2].d = '{-8, -3, -3, -20, -5, -7, -100, -4, -9, -6};
        tbl[2].gaps = 1'b0; tbl[2].exp_max = -3; tbl[2].exp_idx = 1;
        tbl[2].probe_addr = 3; tbl[2].probe_val = -20;

        // reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_max_val", max_val, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        // reset mid-frame after 4 beats aborts at once
        start_frame();
        beats = '{11, 12, 13, 14, 0, 0, 0, 0, 0, 0};
        feed_beats(4, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 0);
        chk("abort_done", done, 0);
        chk("abort_drop_err", drop_err, 0);
        chk("abort_max_val", max_val, 0);
        chk("abort_max_idx", max_idx, 0);
        for (int a = 0; a < 4; a++) begin
            rd_addr = IW'(a);
            #1;
            chk("abort_rd_zero", rd_data, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        // full frames: back-to-back, with gaps, all-negative with tie
        for (int f = 0; f < 3; f++) begin
            beats = tbl[f].d;
            start_frame();
            feed_beats(N_OUT, tbl[f].gaps);
            finish_frame(tbl[f].exp_max, tbl[f].exp_idx, tbl[f].probe_addr, tbl[f].probe_val);
        end

        // beat offered in IDLE is dropped and flagged
        in_valid = 1'b1;
        in_data  = 55;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("drop_err_set", drop_err, 1);
        chk("drop_max_val", max_val, -3);
        chk("drop_max_idx", max_idx, 1);
        rd_addr = 4'd0;
        #1;
        chk("drop_rd0", rd_data, -8);
        rd_addr = 4'd9;
        #1;
        chk("drop_rd9", rd_data, -6);
        step();
        start_frame();
        @(negedge clk);
        chk("start_clears_drop", drop_err, 0);
        chk("start_busy", busy, 1);
        step();

        // restart after 5 beats; the beat coincident with start is discarded
        beats = '{50, 51, 52, 53, 54, 0, 0, 0, 0, 0};
        feed_beats(5, 1'b0);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 999;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        m_first = 1'b1;
        beats = '{100, 101, 102, 103, 104, 105, 106, 107, 108, 109};
        feed_beats(N_OUT, 1'b0);
        finish_frame(109, 9, 0, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
